// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: instruction fetch front end with run/idle FSM, credit-gated prefetch FIFO and redirect flush
// Ports: clock/reset (sync, active-high); enable/start/halt_req steer IDLE/RUN; redir_valid/redir_pc redirect fetch;
//   i_req/i_addr/i_datain drive the instruction memory (data one cycle after i_req);
//   id_valid/id_ready/id_ir/id_pc hand instructions to decode; running is high in RUN.
// Define FETCH_BYPASS_EN to forward a live response straight to decode when the FIFO is empty.
module cpu_fetch_unit #(
  parameter int IW = 16,
  parameter int AW = 8,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  input  logic          halt_req,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc,
  output logic          i_req,
  output logic [AW-1:0] i_addr,
  input  logic [IW-1:0] i_datain,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [IW-1:0] id_ir,
  output logic [AW-1:0] id_pc,
  output logic          running
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic [AW-1:0] r_pc, r_pend_pc, w_pc_nxt, w_res;
  logic r_pend;
  logic [IW-1:0] r_fifo_ir [DEPTH];
  logic [AW-1:0] r_fifo_pc [DEPTH];
  logic [PW:0] r_wr, r_rd, w_cnt, w_occ;
  logic [PW-1:0] w_rd_idx, w_rd_nidx, w_wr_idx;
  logic w_run, w_leave, w_redir, w_flush, w_empty, w_live, w_byp, w_pop, w_pop_fifo, w_push, w_issue;
  always_comb begin
    w_run = r_state == RUN;
    w_leave = w_run & (!enable | halt_req);
    w_redir = w_run & !w_leave & redir_valid;
    w_flush = w_leave | w_redir;
    w_cnt = r_wr - r_rd;
    w_empty = w_cnt == '0;
    w_rd_idx = r_rd[PW-1:0];
    w_rd_nidx = w_rd_idx + PW'(1);
    w_wr_idx = r_wr[PW-1:0];
    w_live = r_pend & w_run & !w_flush;
`ifdef FETCH_BYPASS_EN
    w_byp = w_live & w_empty;
`else
    w_byp = 1'b0;
`endif
    id_valid = (w_run & !w_empty) | w_byp;
    id_ir = !w_empty ? r_fifo_ir[w_rd_idx] : w_byp ? i_datain : '0;
    id_pc = !w_empty ? r_fifo_pc[w_rd_idx] : w_byp ? r_pend_pc : '0;
    w_pop = id_valid & id_ready;
    w_pop_fifo = w_pop & !w_empty;
    w_push = w_live & !(w_byp & id_ready);
    // credit: entries held plus the one in flight, less what decode takes now
    w_occ = w_cnt + (PW+1)'(r_pend) - (PW+1)'(w_pop);
    w_issue = w_run & !w_flush & (w_occ < (PW+1)'(DEPTH));
    // resume at the first address decode has not taken; FIFO, in-flight and pc are consecutive
    w_res = (w_cnt > (PW+1)'(w_pop_fifo)) ? (w_pop_fifo ? r_fifo_pc[w_rd_nidx] : r_fifo_pc[w_rd_idx]) :
            r_pend ? r_pend_pc : r_pc;
    w_pc_nxt = w_leave ? w_res : w_redir ? redir_pc : w_issue ? r_pc + AW'(1) : r_pc;
    w_state_nxt = w_run ? (w_leave ? IDLE : RUN) : ((enable & start) ? RUN : IDLE);
    i_req = w_issue;
    i_addr = r_pc;
    running = w_run;
  end
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= RESET_PC;
      r_pend <= 1'b0;
      r_pend_pc <= '0;
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      r_pend <= w_issue;
      if (w_issue) r_pend_pc <= r_pc;
      if (w_flush) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + (PW+1)'(1);
        if (w_pop_fifo) r_rd <= r_rd + (PW+1)'(1);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_ir[w_wr_idx] <= i_datain;
      r_fifo_pc[w_wr_idx] <= r_pend_pc;
    end
  end
endmodule

// File: tb/tb_cpu_fetch_unit.sv
// tb_cpu_fetch_unit: table-driven check of cpu_fetch_unit plus reset-mid-fetch and PC-wrap sequences
module tb_cpu_fetch_unit;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, enable, start, halt_req, redir_valid, id_ready;
  logic [7:0] redir_pc;
  logic i_req, id_valid, running;
  logic [7:0] i_addr, id_pc;
  logic [15:0] i_datain, id_ir;
  logic w_i_req, w_id_valid, w_running;
  logic [7:0] w_i_addr, w_id_pc;
  logic [15:0] w_i_datain, w_id_ir;
  int checks = 0;
  int errors = 0;
  cpu_fetch_unit u_dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .halt_req(halt_req),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .i_req(i_req), .i_addr(i_addr),
    .i_datain(i_datain), .id_valid(id_valid), .id_ready(id_ready), .id_ir(id_ir),
    .id_pc(id_pc), .running(running)
  );
  cpu_fetch_unit #(.RESET_PC(8'hFE)) u_wrap (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .halt_req(halt_req),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .i_req(w_i_req), .i_addr(w_i_addr),
    .i_datain(w_i_datain), .id_valid(w_id_valid), .id_ready(id_ready), .id_ir(w_id_ir),
    .id_pc(w_id_pc), .running(w_running)
  );
  logic m_q, wm_q;
  logic [7:0] m_a, wm_a;
  always @(posedge clock) begin
    m_q <= i_req;
    m_a <= i_addr;
    wm_q <= w_i_req;
    wm_a <= w_i_addr;
  end
  assign i_datain = m_q ? 16'h0100 + {8'h00, m_a} : 16'hDEAD;
  assign w_i_datain = wm_q ? 16'h0100 + {8'h00, wm_a} : 16'hDEAD;
  int tok = 0;
  logic ovf = 1'b0;
  always @(posedge clock) begin
    if (reset || (running && (halt_req || !enable || redir_valid))) tok <= 0;
    else tok <= tok + int'(i_req) - int'(id_valid && id_ready);
  end
  always @(negedge clock) if (tok > 4) ovf <= 1'b1;
  typedef struct {
    logic rst, en, st, hl, rv;
    logic [7:0] rpc;
    logic rdy, req;
    logic [7:0] addr;
    logic vld;
    logic [7:0] pc;
    logic run;
  } vec_t;
  function automatic vec_t mk(int r, int e, int s, int h, int v, int p, int y, int q, int a, int d, int c, int n);
    mk.rst = r[0]; mk.en = e[0]; mk.st = s[0]; mk.hl = h[0]; mk.rv = v[0]; mk.rpc = p[7:0];
    mk.rdy = y[0]; mk.req = q[0]; mk.addr = a[7:0]; mk.vld = d[0]; mk.pc = c[7:0]; mk.run = n[0];
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  initial begin
    vec_t tv[36];
    logic [7:0] wp;
    tv[0]  = mk(0,1,1,0,0,0,0,    0,'h00,0,'h00,0);
    tv[1]  = mk(0,1,0,0,0,0,0,    1,'h00,0,'h00,1);
    tv[2]  = mk(0,1,0,0,0,0,0,    1,'h01,0,'h00,1);
    tv[3]  = mk(0,1,0,0,0,0,0,    1,'h02,1,'h00,1);
    tv[4]  = mk(0,1,0,0,0,0,0,    1,'h03,1,'h00,1);
    for (int i = 5; i < 10; i++) tv[i] = mk(0,1,0,0,0,0,0, 0,'h04,1,'h00,1);
    tv[10] = mk(0,1,0,0,0,0,1,    1,'h04,1,'h00,1);
    tv[11] = mk(0,1,0,0,0,0,1,    1,'h05,1,'h01,1);
    tv[12] = mk(0,1,0,0,0,0,1,    1,'h06,1,'h02,1);
    tv[13] = mk(0,1,0,0,0,0,1,    1,'h07,1,'h03,1);
    tv[14] = mk(0,1,0,0,0,0,1,    1,'h08,1,'h04,1);
    tv[15] = mk(0,1,0,0,1,'h40,0, 0,'h09,1,'h05,1);
    tv[16] = mk(0,1,0,0,0,0,1,    1,'h40,0,'h00,1);
    tv[17] = mk(0,1,0,0,0,0,1,    1,'h41,0,'h00,1);
    tv[18] = mk(0,1,0,0,0,0,1,    1,'h42,1,'h40,1);
    tv[19] = mk(0,1,0,0,0,0,1,    1,'h43,1,'h41,1);
    tv[20] = mk(0,1,0,0,0,0,1,    1,'h44,1,'h42,1);
    tv[21] = mk(0,1,0,1,0,0,0,    0,'h45,1,'h43,1);
    tv[22] = mk(0,1,0,0,0,0,1,    0,'h43,0,'h00,0);
    tv[23] = mk(0,1,1,0,0,0,1,    0,'h43,0,'h00,0);
    tv[24] = mk(0,1,0,0,0,0,1,    1,'h43,0,'h00,1);
    tv[25] = mk(0,1,0,0,0,0,1,    1,'h44,0,'h00,1);
    tv[26] = mk(0,1,0,0,0,0,1,    1,'h45,1,'h43,1);
    tv[27] = mk(0,1,0,0,0,0,1,    1,'h46,1,'h44,1);
    tv[28] = mk(0,1,0,1,0,0,1,    0,'h47,1,'h45,1);
    tv[29] = mk(0,0,1,0,0,0,1,    0,'h46,0,'h00,0);
    tv[30] = mk(0,1,1,0,0,0,1,    0,'h46,0,'h00,0);
    tv[31] = mk(0,1,0,0,0,0,1,    1,'h46,0,'h00,1);
    tv[32] = mk(0,1,0,0,0,0,1,    1,'h47,0,'h00,1);
    tv[33] = mk(0,1,0,0,0,0,1,    1,'h48,1,'h46,1);
    tv[34] = mk(0,0,0,0,0,0,1,    0,'h49,1,'h47,1);
    tv[35] = mk(0,0,0,0,0,0,1,    0,'h48,0,'h00,0);
    reset = 1'b1; enable = 1'b0; start = 1'b0; halt_req = 1'b0;
    redir_valid = 1'b0; redir_pc = 8'h00; id_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset i_req", 16'(i_req), 16'h0);
    chk("reset i_addr", 16'(i_addr), 16'h0);
    chk("reset id_valid", 16'(id_valid), 16'h0);
    chk("reset id_ir", id_ir, 16'h0);
    chk("reset id_pc", 16'(id_pc), 16'h0);
    chk("reset running", 16'(running), 16'h0);
    chk("reset wrap i_addr", 16'(w_i_addr), 16'h00FE);
    for (int i = 0; i < 36; i++) begin
      reset = tv[i].rst; enable = tv[i].en; start = tv[i].st; halt_req = tv[i].hl;
      redir_valid = tv[i].rv; redir_pc = tv[i].rpc; id_ready = tv[i].rdy;
      @(negedge clock);
      chk($sformatf("c%0d i_req", i), 16'(i_req), 16'(tv[i].req));
      chk($sformatf("c%0d i_addr", i), 16'(i_addr), 16'(tv[i].addr));
      chk($sformatf("c%0d id_valid", i), 16'(id_valid), 16'(tv[i].vld));
      chk($sformatf("c%0d id_pc", i), 16'(id_pc), 16'(tv[i].pc));
      chk($sformatf("c%0d id_ir", i), id_ir, tv[i].vld ? 16'h0100 + 16'(tv[i].pc) : 16'h0);
      chk($sformatf("c%0d running", i), 16'(running), 16'(tv[i].run));
      tick;
    end
    enable = 1'b1; start = 1'b1; id_ready = 1'b1;
    tick;
    start = 1'b0;
    @(negedge clock);
    chk("rst-seq i_req", 16'(i_req), 16'h1);
    chk("rst-seq i_addr", 16'(i_addr), 16'h0048);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clock);
    chk("post-reset id_valid", 16'(id_valid), 16'h0);
    chk("post-reset i_addr", 16'(i_addr), 16'h0);
    chk("post-reset i_req", 16'(i_req), 16'h0);
    chk("post-reset running", 16'(running), 16'h0);
    chk("post-reset id_ir", id_ir, 16'h0);
    chk("post-reset wrap i_addr", 16'(w_i_addr), 16'h00FE);
    tick;
    start = 1'b1;
    @(negedge clock);
    chk("idle id_valid", 16'(id_valid), 16'h0);
    tick;
    start = 1'b0;
    @(negedge clock);
    chk("restart i_req", 16'(i_req), 16'h1);
    chk("restart i_addr", 16'(i_addr), 16'h0);
    chk("wrap first i_addr", 16'(w_i_addr), 16'h00FE);
    tick;
    @(negedge clock);
    chk("restart gap id_valid", 16'(id_valid), 16'h0);
    chk("wrap gap id_valid", 16'(w_id_valid), 16'h0);
    tick;
    for (int k = 0; k < 4; k++) begin
      wp = 8'hFE + 8'(k);
      @(negedge clock);
      chk($sformatf("stream%0d id_valid", k), 16'(id_valid), 16'h1);
      chk($sformatf("stream%0d id_pc", k), 16'(id_pc), 16'(k));
      chk($sformatf("stream%0d id_ir", k), id_ir, 16'h0100 + 16'(k));
      chk($sformatf("wrap%0d id_pc", k), 16'(w_id_pc), 16'(wp));
      chk($sformatf("wrap%0d id_ir", k), w_id_ir, 16'h0100 + 16'(wp));
      tick;
    end
    chk("fifo overflow", 16'(ovf), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
